cpu_mem_responder: RTL and testbench
====================================

# cpu_mem_responder

Memory-side responder for the 16-bit CPU's instruction and data buses. It owns the instruction RAM and data RAM that the CPU fetches from and loads/stores to. A host load port fills both RAMs. A sequencing FSM then enables and starts the CPU, serves its bus traffic, and stops it on a HALT fetch. It sits between the CPU and the bench/host, replacing hand-driven `i_datain`/`d_datain` stimulus.

## Interface
- `IADDR_W`, 8, instruction address width (CPU `pc`)
- `DADDR_W`, 8, data address width (CPU `d_addr`)
- `DATA_W`, 16, instruction/data word width
- `HALT_OP`, 5'b00001, opcode in `i_datain[15:11]` treated as HALT
- `START_DELAY`, 2, cycles `cpu_enable` is high before the `cpu_start` pulse (≥1)

Ports:
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low
- `ld_valid`  in  1  host load word valid
- `ld_ready`  out  1  responder accepts load words
- `ld_sel`  in  1  0 = instruction RAM, 1 = data RAM
- `ld_addr`  in  8  load address (low `IADDR_W`/`DADDR_W` bits used)
- `ld_data`  in  16  load word
- `ld_done`  in  1  host finished loading; arms the CPU
- `rearm`  in  1  rerun the loaded program from `DONE`
- `i_addr`  in  `IADDR_W`  CPU fetch address
- `i_datain`  out  16  instruction word to CPU
- `d_addr`  in  `DADDR_W`  CPU data address
- `d_dataout`  in  16  CPU store data
- `d_we`  in  1  CPU store strobe
- `d_datain`  out  16  load data to CPU
- `cpu_enable`  out  1  CPU enable
- `cpu_start`  out  1  one-cycle CPU start pulse
- `halted`  out  1  HALT fetched, CPU stopped
- `st_count`  out  16  stores accepted since last arm

## Operation
- FSM states: `LOAD`, `ARM`, `START`, `RUN`, `DONE`.
- `LOAD`
  - `ld_ready`=1.
  - A cycle with `ld_valid` writes `ld_data` to the RAM chosen by `ld_sel` at `ld_addr`.
  - `ld_done` moves to `ARM`. If `ld_valid` is high in the same cycle, that word is still written.
- `ARM`
  - `cpu_enable`=1.
  - Counter loads `START_DELAY-1` on entry and decrements; at 0, go to `START`.
- `START`: `cpu_start`=1 for exactly one cycle, then `RUN`.
- `RUN`
  - `i_datain` = imem[`i_addr`]; `d_datain` = dmem[`d_addr`]. Both are combinational reads.
  - `d_we` writes `d_dataout` to dmem[`d_addr`] at the clock edge and increments `st_count`. `st_count` saturates at 16'hFFFF.
  - Read-during-write to the same address returns the old word until the edge.
- `DONE`
  - `halted`=1, `cpu_enable`=0.
  - `i_datain` is forced to 0 (NOP encoding); `d_datain` still reads dmem.
  - `rearm` goes to `ARM` and clears `st_count`. RAM contents are kept.
- Outside `RUN`:
  - `d_we` is ignored, and `st_count` does not change.
  - `i_datain`/`d_datain` read normally, except `DONE`, where `i_datain`=0.
- In any state other than `LOAD`:
  - `ld_valid` is ignored and `ld_ready`=0.
  - `ld_done` is ignored.
- `rearm` is ignored outside `DONE`.

## Timing
- Reset values: state `LOAD`, `ld_ready`=1, `cpu_enable`=0, `cpu_start`=0, `halted`=0, `st_count`=0. RAM contents are not cleared.
- Reset asserted mid-`RUN` returns to `LOAD` immediately and asynchronously. Stores in flight that cycle are dropped.
- Load write latency: 1 edge. A word is readable on `i_datain`/`d_datain` in the cycle after acceptance.
- `ld_done` edge to `cpu_enable`=1: 1 cycle.
- `cpu_enable` rises `START_DELAY` cycles before `cpu_start`.
- `cpu_start` is high for exactly 1 cycle, and `cpu_enable` stays high through it.
- Store latency: 1 edge. `st_count` updates on the same edge as the write.

## Configuration
- `CPU_MEM_HALT_DETECT_EN` defined:
  - In `RUN`, the edge sampling `i_datain[15:11]==HALT_OP` moves to `DONE`.
  - From that edge, `cpu_enable`=0 and `halted`=1.
  - A `d_we` in the HALT cycle is still written.
- Not defined:
  - `DONE` is unreachable; `RUN` persists until reset.
  - `halted` is tied 0 and `rearm` is unused.

## Test plan
- Reset low then high; check state outputs.
  - Required: `ld_ready`=1, `cpu_enable`=0, `cpu_start`=0, `st_count`=0.
- Load imem[0]=16'h0801, dmem[5]=16'hBEEF, then `ld_done`.
  - `cpu_enable` rises 1 cycle later.
  - `cpu_start` pulses for 1 cycle, 2 cycles after that (`START_DELAY`=2).
  - `i_addr`=0 gives `i_datain`=16'h0801.
- In `RUN`, `d_addr`=5.
  - `d_datain`=16'hBEEF.
  - Then `d_we`=1 with `d_dataout`=16'h1234: `d_datain`=16'hBEEF that cycle, 16'h1234 the next, `st_count`=1.
- With the macro, imem[3]={`HALT_OP`,11'b0} and `i_addr`=3 in `RUN`.
  - Next cycle: `halted`=1, `cpu_enable`=0, `i_datain`=0.
  - `rearm` then gives `cpu_start` again after 2 cycles, with `st_count`=0.
- `d_we`=1 with `d_addr`=7 during `LOAD`: dmem[7] is unchanged and `st_count`=0.
- `ld_valid`=1 during `RUN`: `ld_ready`=0 and imem is unchanged.
- Reset low mid-`RUN`: outputs take reset values immediately, and dmem[5] keeps 16'h1234.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 16-bit CPU: instruction and data RAMs, a host load port and
// a sequencer that arms, starts and (optionally) stops the CPU.
// Optional HALT detection is enabled by defining CPU_MEM_HALT_DETECT_EN.
module cpu_mem_responder #(
   parameter int unsigned IADDR_W     = 8,
   parameter int unsigned DADDR_W     = 8,
   parameter int unsigned DATA_W      = 16,
   parameter logic [4:0]  HALT_OP     = 5'b00001,
   parameter int unsigned START_DELAY = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic               ld_sel,
   input  logic [7:0]         ld_addr,
   input  logic [DATA_W-1:0]  ld_data,
   input  logic               ld_done,
   input  logic               rearm,
   input  logic [IADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0]  i_datain,
   input  logic [DADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0]  d_dataout,
   input  logic               d_we,
   output logic [DATA_W-1:0]  d_datain,
   output logic               cpu_enable,
   output logic               cpu_start,
   output logic               halted,
   output logic [15:0]        st_count
);

   localparam int unsigned CNT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

   typedef enum logic [2:0] {StLoad, StArm, StStart, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        st_count_q, st_count_d;

   logic [DATA_W-1:0]  imem [2**IADDR_W];
   logic [DATA_W-1:0]  dmem [2**DADDR_W];

   logic               imem_we;
   logic               dmem_we;
   logic [DADDR_W-1:0] dmem_waddr;
   logic [DATA_W-1:0]  dmem_wdata;
   logic [DATA_W-1:0]  imem_rd;

`ifndef CPU_MEM_HALT_DETECT_EN
   // Without HALT detection these inputs have no effect.
   logic unused_cfg;
   assign unused_cfg = rearm ^ (^HALT_OP);
`endif

   // Combinational RAM reads; instruction bus is forced to NOP once halted.
   always_comb begin
      imem_rd  = imem[i_addr];
      i_datain = (state_q == StDone) ? '0 : imem_rd;
      d_datain = dmem[d_addr];
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clock) begin
      if (imem_we) imem[ld_addr[IADDR_W-1:0]] <= ld_data;
      if (dmem_we) dmem[dmem_waddr] <= dmem_wdata;
   end

   // State, start-delay counter and store counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StLoad;
         cnt_q      <= '0;
         st_count_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         st_count_q <= st_count_d;
      end
   end

   assign st_count = st_count_q;

   // Sequencer next-state, RAM write selection and CPU control outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      st_count_d = st_count_q;
      ld_ready   = 1'b0;
      cpu_enable = 1'b0;
      cpu_start  = 1'b0;
      halted     = 1'b0;
      imem_we    = 1'b0;
      dmem_we    = 1'b0;
      dmem_waddr = ld_addr[DADDR_W-1:0];
      dmem_wdata = ld_data;

      unique case (state_q)
         StLoad: begin
            ld_ready = 1'b1;
            if (ld_valid) begin
               if (ld_sel) dmem_we = 1'b1;
               else        imem_we = 1'b1;
            end
            if (ld_done) begin
               state_d = StArm;
               cnt_d   = CNT_W'(START_DELAY - 1);
            end
         end
         StArm: begin
            cpu_enable = 1'b1;
            if (cnt_q == '0) state_d = StStart;
            else             cnt_d   = cnt_q - 1'b1;
         end
         StStart: begin
            cpu_enable = 1'b1;
            cpu_start  = 1'b1;
            state_d    = StRun;
         end
         StRun: begin
            cpu_enable = 1'b1;
            if (d_we) begin
               dmem_we    = 1'b1;
               dmem_waddr = d_addr;
               dmem_wdata = d_dataout;
               if (st_count_q != 16'hFFFF) st_count_d = st_count_q + 16'd1;
            end
`ifdef CPU_MEM_HALT_DETECT_EN
            // A store issued alongside the HALT fetch still lands.
            if (imem_rd[DATA_W-1 -: 5] == HALT_OP) state_d = StDone;
`endif
         end
         StDone: begin
`ifdef CPU_MEM_HALT_DETECT_EN
            halted = 1'b1;
            if (rearm) begin
               state_d    = StArm;
               cnt_d      = CNT_W'(START_DELAY - 1);
               st_count_d = '0;
            end
`endif
         end
         default: state_d = StLoad;
      endcase
   end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: randomized loads and stores checked against
// plain array models of both RAMs and a store counter.
module tb_cpu_mem_responder;

   localparam logic [4:0] HALT = 5'b00001;
   localparam int         DELAY = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        ld_valid, ld_ready, ld_sel, ld_done, rearm, d_we;
   logic [7:0]  ld_addr, i_addr, d_addr;
   logic [15:0] ld_data, i_datain, d_dataout, d_datain, st_count;
   logic        cpu_enable, cpu_start, halted;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] imem_m [256];
   logic [15:0] dmem_m [256];
   int          cnt_m = 0;

   cpu_mem_responder dut (
      .clock      (clock),
      .reset      (reset),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_sel     (ld_sel),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .ld_done    (ld_done),
      .rearm      (rearm),
      .i_addr     (i_addr),
      .i_datain   (i_datain),
      .d_addr     (d_addr),
      .d_dataout  (d_dataout),
      .d_we       (d_we),
      .d_datain   (d_datain),
      .cpu_enable (cpu_enable),
      .cpu_start  (cpu_start),
      .halted     (halted),
      .st_count   (st_count)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] safe_word();
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:11] == HALT) w[15] = 1'b1;
      return w;
   endfunction

   task automatic idle_inputs();
      ld_valid = 0; ld_sel = 0; ld_addr = 0; ld_data = 0; ld_done = 0; rearm = 0;
      i_addr = 0; d_addr = 0; d_dataout = 0; d_we = 0;
   endtask

   task automatic load_word(input logic sel, input logic [7:0] a, input logic [15:0] w);
      ld_valid = 1; ld_sel = sel; ld_addr = a; ld_data = w;
      @(posedge clock);
      if (sel) dmem_m[a] = w;
      else     imem_m[a] = w;
      #1;
      ld_valid = 0;
   endtask

   task automatic test_reset();
      reset = 0;
      idle_inputs();
      #12;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
      checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL reset_cpu_enable got %b want 0", cpu_enable); end
      checks++; if (cpu_start !== 1'b0) begin errors++; $display("FAIL reset_cpu_start got %b want 0", cpu_start); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
      checks++; if (st_count !== 16'd0) begin errors++; $display("FAIL reset_st_count got %h want 0", st_count); end
      @(negedge clock);
      reset = 1;
      step();
   endtask

   // Fill both RAMs; each word is read back the cycle after it is accepted.
   task automatic test_load();
      logic       prev_sel;
      logic [7:0] prev_a;
      prev_sel = 0; prev_a = 0;
      for (int i = 0; i < 512; i++) begin
         logic [7:0]  a;
         logic [15:0] w;
         a = 8'(i % 256);
         w = safe_word();
         ld_valid = 1; ld_sel = (i >= 256); ld_addr = a; ld_data = w;
         i_addr = prev_a; d_addr = prev_a;
         @(negedge clock);
         if (i > 0) begin
            checks++;
            if (prev_sel) begin
               if (d_datain !== dmem_m[prev_a]) begin
                  errors++; $display("FAIL load_dmem[%0d] got %h want %h", prev_a, d_datain, dmem_m[prev_a]);
               end
            end else if (i_datain !== imem_m[prev_a]) begin
               errors++; $display("FAIL load_imem[%0d] got %h want %h", prev_a, i_datain, imem_m[prev_a]);
            end
         end
         checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ld_ready got %b want 1", ld_ready); end
         @(posedge clock);
         if (i >= 256) dmem_m[a] = w;
         else          imem_m[a] = w;
         #1;
         prev_sel = (i >= 256); prev_a = a;
      end
      ld_valid = 0;
      load_word(0, 8'd0, 16'h0801);
      load_word(0, 8'd3, {HALT, 11'b0});
      load_word(1, 8'd5, 16'hBEEF);
      load_word(1, 8'd7, 16'h5A5A);
      // Store strobe while loading must be ignored.
      d_we = 1; d_addr = 7; d_dataout = 16'hFFFF;
      step();
      d_we = 0;
      @(negedge clock);
      checks++; if (d_datain !== 16'h5A5A) begin errors++; $display("FAIL load_dwe_ignored got %h want 5a5a", d_datain); end
      checks++; if (st_count !== 16'd0) begin errors++; $display("FAIL load_st_count got %h want 0", st_count); end
      step();
   endtask

   // Arm-to-start sequence; entered in the first cycle after ld_done or rearm.
   task automatic test_arm();
      int n;
      bit seen;
      n = 0; seen = 0;
      i_addr = 0; d_addr = 5;
      @(negedge clock);
      checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL arm_cpu_enable got %b want 1", cpu_enable); end
      checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL arm_ld_ready got %b want 0", ld_ready); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL arm_halted got %b want 0", halted); end
      checks++; if (st_count !== 16'(cnt_m)) begin errors++; $display("FAIL arm_st_count got %h want %h", st_count, 16'(cnt_m)); end
      checks++; if (i_datain !== imem_m[0]) begin errors++; $display("FAIL arm_i_datain got %h want %h", i_datain, imem_m[0]); end
      checks++; if (d_datain !== dmem_m[5]) begin errors++; $display("FAIL arm_d_datain got %h want %h", d_datain, dmem_m[5]); end
      i_addr = 1;
      while (!seen && n < 8) begin
         if (cpu_start === 1'b1) begin
            seen = 1;
            checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL start_cpu_enable got %b want 1", cpu_enable); end
         end else begin
            n++;
            @(negedge clock);
         end
      end
      checks++; if (!seen || n != DELAY) begin errors++; $display("FAIL start_delay got %0d seen %0d want %0d", n, seen, DELAY); end
      @(negedge clock);
      checks++; if (cpu_start !== 1'b0) begin errors++; $display("FAIL start_pulse_width got %b want 0", cpu_start); end
      checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL run_cpu_enable got %b want 1", cpu_enable); end
      step();
   endtask

   task automatic test_done_and_arm();
      logic [15:0] w;
      w = 16'($urandom);
      ld_valid = 1; ld_sel = 1; ld_addr = 9; ld_data = w; ld_done = 1;
      @(negedge clock);
      checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL done_cycle_cpu_enable got %b want 0", cpu_enable); end
      @(posedge clock);
      dmem_m[9] = w;
      #1;
      ld_valid = 0; ld_done = 0;
      d_addr = 9;
      #1;
      checks++; if (d_datain !== w) begin errors++; $display("FAIL done_word_written got %h want %h", d_datain, w); end
      cnt_m = 0;
      test_arm();
   endtask

   task automatic test_run_store();
      i_addr = 1; d_addr = 5; d_we = 0;
      @(negedge clock);
      checks++; if (d_datain !== 16'hBEEF) begin errors++; $display("FAIL run_read5 got %h want beef", d_datain); end
      step();
      d_we = 1; d_dataout = 16'h1234;
      @(negedge clock);
      checks++; if (d_datain !== 16'hBEEF) begin errors++; $display("FAIL run_rdw_old got %h want beef", d_datain); end
      @(posedge clock);
      dmem_m[5] = 16'h1234; cnt_m++;
      #1;
      d_we = 0;
      @(negedge clock);
      checks++; if (d_datain !== 16'h1234) begin errors++; $display("FAIL run_store_new got %h want 1234", d_datain); end
      checks++; if (st_count !== 16'd1) begin errors++; $display("FAIL run_st_count got %h want 1", st_count); end
      step();
   endtask

   // Random bus traffic plus ignored host loads while the CPU runs.
   task automatic test_random_traffic();
      for (int k = 0; k < 60; k++) begin
         i_addr = 8'($urandom);
         if (i_addr == 0 || i_addr == 3) i_addr = 1;
         d_addr = 8'($urandom);
         if (d_addr == 5) d_addr = 6;
         d_we = 1'($urandom); d_dataout = 16'($urandom);
         ld_valid = 1'($urandom); ld_sel = 1'($urandom);
         ld_addr = 8'($urandom); ld_data = 16'($urandom);
         @(negedge clock);
         checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL rnd_ld_ready got %b want 0", ld_ready); end
         checks++; if (i_datain !== imem_m[i_addr]) begin errors++; $display("FAIL rnd_i_datain[%0d] got %h want %h", i_addr, i_datain, imem_m[i_addr]); end
         checks++; if (d_datain !== dmem_m[d_addr]) begin errors++; $display("FAIL rnd_d_datain[%0d] got %h want %h", d_addr, d_datain, dmem_m[d_addr]); end
         checks++; if (st_count !== 16'(cnt_m)) begin errors++; $display("FAIL rnd_st_count got %h want %h", st_count, 16'(cnt_m)); end
         checks++; if (cpu_enable !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL rnd_run_state got en %b halt %b want 1 0", cpu_enable, halted); end
         @(posedge clock);
         if (d_we) begin
            dmem_m[d_addr] = d_dataout;
            if (cnt_m < 65535) cnt_m++;
         end
         #1;
      end
      d_we = 0; ld_valid = 0; i_addr = 1;
   endtask

`ifdef CPU_MEM_HALT_DETECT_EN
   task automatic test_halt();
      logic [15:0] w;
      w = 16'($urandom);
      i_addr = 3; d_we = 1; d_addr = 8; d_dataout = w;
      @(negedge clock);
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_pre got %b want 0", halted); end
      @(posedge clock);
      dmem_m[8] = w; cnt_m++;
      #1;
      d_dataout = ~w;
      @(negedge clock);
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted got %b want 1", halted); end
      checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL halt_cpu_enable got %b want 0", cpu_enable); end
      checks++; if (i_datain !== 16'h0000) begin errors++; $display("FAIL halt_i_datain got %h want 0", i_datain); end
      checks++; if (d_datain !== dmem_m[8]) begin errors++; $display("FAIL halt_store got %h want %h", d_datain, dmem_m[8]); end
      checks++; if (st_count !== 16'(cnt_m)) begin errors++; $display("FAIL halt_st_count got %h want %h", st_count, 16'(cnt_m)); end
      step();
      d_we = 0;
      @(negedge clock);
      checks++; if (d_datain !== dmem_m[8]) begin errors++; $display("FAIL done_dwe_ignored got %h want %h", d_datain, dmem_m[8]); end
      checks++; if (st_count !== 16'(cnt_m)) begin errors++; $display("FAIL done_st_count got %h want %h", st_count, 16'(cnt_m)); end
      step();
      rearm = 1;
      step();
      rearm = 0;
      cnt_m = 0;
      test_arm();
   endtask
`else
   task automatic test_no_halt();
      i_addr = 3;
      step();
      step();
      @(negedge clock);
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL nohalt_halted got %b want 0", halted); end
      checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL nohalt_cpu_enable got %b want 1", cpu_enable); end
      i_addr = 1;
      step();
   endtask
`endif

   task automatic test_reset_mid_run();
      d_we = 1; d_addr = 5; d_dataout = 16'hDEAD;
      #1;
      reset = 0;
      #1;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL rst_run_ld_ready got %b want 1", ld_ready); end
      checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL rst_run_cpu_enable got %b want 0", cpu_enable); end
      checks++; if (cpu_start !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_run_start_halt got %b %b want 0 0", cpu_start, halted); end
      checks++; if (st_count !== 16'd0) begin errors++; $display("FAIL rst_run_st_count got %h want 0", st_count); end
      step();
      d_we = 0;
      @(negedge clock);
      reset = 1;
      #2;
      checks++; if (d_datain !== dmem_m[5]) begin errors++; $display("FAIL rst_run_dmem5 got %h want %h", d_datain, dmem_m[5]); end
      step();
   endtask

   initial begin
      test_reset();
      test_load();
      test_done_and_arm();
      test_run_store();
      test_random_traffic();
`ifdef CPU_MEM_HALT_DETECT_EN
      test_halt();
`else
      test_no_halt();
`endif
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
